// File: rtl/seq_div32.sv
// seq_div32: multi-cycle signed divider, restoring shift-subtract, one quotient
// bit per clock. Quotient on z_low, remainder on z_high; ready pulses once
// when results are valid. Divide-by-zero finishes in a single edge.
module seq_div32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] z_low,
  output logic [WIDTH-1:0] z_high,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   rem;
  logic             qneg;
  logic             rneg;

  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] quo_sh;

  // Operand magnitudes and one restoring iteration step.
  // Magnitudes are unsigned, so |0x80000000| stays 0x80000000.
  always_comb begin
    dvd_abs = dividend[WIDTH-1] ? ('0 - dividend) : dividend;
    dvs_abs = divisor[WIDTH-1]  ? ('0 - divisor)  : divisor;
    rem_sh  = (rem << 1) | {{WIDTH{1'b0}}, quo[WIDTH-1]};
    trial   = rem_sh - {1'b0, dvs};
    quo_sh  = {quo[WIDTH-2:0], ~trial[WIDTH]};
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      quo         <= '0;
      dvs         <= '0;
      rem         <= '0;
      qneg        <= 1'b0;
      rneg        <= 1'b0;
      busy        <= 1'b0;
      ready       <= 1'b0;
      z_low       <= '0;
      z_high      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              z_low       <= '1;
              z_high      <= dividend;
              div_by_zero <= 1'b1;
              ready       <= 1'b1;
            end else begin
              quo         <= dvd_abs;
              dvs         <= dvs_abs;
              rem         <= '0;
              count       <= '0;
              qneg        <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              rneg        <= dividend[WIDTH-1];
              busy        <= 1'b1;
              div_by_zero <= 1'b0;
              state       <= RUN;
            end
          end
        end
        RUN: begin
          rem   <= trial[WIDTH] ? rem_sh : trial;
          quo   <= quo_sh;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          z_low  <= qneg ? ('0 - quo) : quo;
          z_high <= rneg ? ('0 - rem[WIDTH-1:0]) : rem[WIDTH-1:0];
          ready  <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div32.sv
// Directed testbench for seq_div32: hand-computed quotient/remainder vectors,
// latency, busy duration, divide-by-zero, ignored restart and mid-op reset.
module tb_seq_div32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        ready;
  logic [31:0] z_low;
  logic [31:0] z_high;
  logic        div_by_zero;

  int unsigned checks = 0;
  int unsigned errors = 0;

  seq_div32 #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .ready(ready), .z_low(z_low), .z_high(z_high),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one division and wait (bounded) for ready; lat counts edges after E0.
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input int unsigned exp_lat, input logic [31:0] exp_q,
                        input logic [31:0] exp_r, input logic exp_dz);
    int unsigned lat;
    int unsigned busy_cnt;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    step();
    start    = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    while (!ready && lat < 50) begin
      if (busy) busy_cnt++;
      step();
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy_cycles"}, busy_cnt, (exp_lat == 0) ? 0 : exp_lat);
    check({tag, " busy_at_ready"}, {31'd0, busy}, 32'd0);
    check({tag, " z_low"}, z_low, exp_q);
    check({tag, " z_high"}, z_high, exp_r);
    check({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, exp_dz});
    step();
    check({tag, " ready_pulse"}, {31'd0, ready}, 32'd0);
  endtask

  initial begin
    int unsigned lat;
    int unsigned rdy_cnt;

    // Reset state
    step();
    step();
    rst = 1'b0;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst ready", {31'd0, ready}, 32'd0);
    check("rst z_low", z_low, 32'd0);
    check("rst z_high", z_high, 32'd0);
    check("rst dbz", {31'd0, div_by_zero}, 32'd0);

    // Signed quotient/remainder vectors
    do_div("100/7",   32'd100,        32'd7,          33, 32'd14,         32'd2,          1'b0);
    do_div("-100/7",  32'hFFFFFF9C,   32'd7,          33, 32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0);
    do_div("100/-7",  32'd100,        32'hFFFFFFF9,   33, 32'hFFFFFFF2,   32'd2,          1'b0);
    do_div("-7/-2",   32'hFFFFFFF9,   32'hFFFFFFFE,   33, 32'd3,          32'hFFFFFFFF,   1'b0);
    do_div("3/10",    32'd3,          32'd10,         33, 32'd0,          32'd3,          1'b0);
    do_div("0/5",     32'd0,          32'd5,          33, 32'd0,          32'd0,          1'b0);
    do_div("max/1",   32'h7FFFFFFF,   32'd1,          33, 32'h7FFFFFFF,   32'd0,          1'b0);

    // Divide by zero, then a normal op clears the flag
    do_div("7/0",     32'd7,          32'd0,          0,  32'hFFFFFFFF,   32'd7,          1'b1);
    do_div("9/3",     32'd9,          32'd3,          33, 32'd3,          32'd0,          1'b0);

    // Most-negative dividend cases
    do_div("min/-1",  32'h80000000,   32'hFFFFFFFF,   33, 32'h80000000,   32'd0,          1'b0);
    do_div("min/2",   32'h80000000,   32'd2,          33, 32'hC0000000,   32'd0,          1'b0);

    // Start during RUN is ignored; operands changed mid-run have no effect
    dividend = 32'd50;
    divisor  = 32'd5;
    start    = 1'b1;
    step();                               // E0
    start = 1'b0;
    for (int i = 1; i < 10; i++) step();  // now just after E9
    start    = 1'b1;
    dividend = 32'd1;
    divisor  = 32'd1;
    step();                               // E10 samples the stray start
    start   = 1'b0;
    lat     = 10;
    rdy_cnt = 0;
    while (!ready && lat < 60) begin
      step();
      lat++;
    end
    check("restart latency", lat, 33);
    check("restart z_low", z_low, 32'd10);
    check("restart z_high", z_high, 32'd0);
    for (int i = 0; i < 40; i++) begin
      step();
      if (ready) rdy_cnt++;
    end
    check("restart extra_ready", rdy_cnt, 0);

    // Reset mid-operation aborts without a ready pulse
    dividend = 32'd1000;
    divisor  = 32'd3;
    start    = 1'b1;
    step();                               // E0
    start = 1'b0;
    for (int i = 1; i < 10; i++) step();
    rst = 1'b1;
    step();                               // E10 with reset
    rst = 1'b0;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort z_low", z_low, 32'd0);
    check("abort z_high", z_high, 32'd0);
    rdy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready || busy) rdy_cnt++;
      step();
    end
    check("abort no_ready", rdy_cnt, 0);
    do_div("1000/3",  32'd1000,       32'd3,          33, 32'd333,        32'd1,          1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_div32.md
Name: seq_div32

Overview:
- Multi-cycle signed 32-bit divider serving the ALU DIV opcode (4'b0011).
- A restoring shift-subtract engine runs one quotient bit per clock.
- Results are presented on z_low (quotient) and z_high (remainder) for the ALU to route into the Z register pair.
- The ALU raises start and waits for ready before latching Z.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- dividend  input  WIDTH  signed dividend (ALU A operand)
- divisor  input  WIDTH  signed divisor (ALU B operand)
- busy  output  1  high while a division is in progress
- ready  output  1  one-cycle pulse, results valid
- z_low  output  WIDTH  signed quotient
- z_high  output  WIDTH  signed remainder
- div_by_zero  output  1  sticky-until-next-start flag: last division had divisor==0

Behaviour:
- Reset value of all outputs: busy=0, ready=0, z_low=0, z_high=0, div_by_zero=0, state=IDLE, count=0.
- Reset has priority over every other input.
- A reset asserted mid-operation aborts the division at that edge. No ready pulse is produced for the aborted operation.
- States: IDLE, RUN, FIX.
- IDLE, edge where start=1 (edge E0):
  - Latch magnitudes |dividend| and |divisor| as unsigned WIDTH-bit values.
  - Latch qneg = dividend[31]^divisor[31] and rneg = dividend[31].
  - Clear the partial remainder (WIDTH+1 bits) and count.
  - Set busy=1, clear div_by_zero, go to RUN.
  - Special case, divisor==0 at E0: do not enter RUN. Instead:
    - z_low=32'hFFFFFFFF, z_high=dividend (unmodified), div_by_zero=1.
    - ready=1 for the cycle after E0, busy stays 0, remain in IDLE.
- RUN, edges E1..E32, one iteration per edge:
  - Shift {rem, quo} left by 1.
  - trial = rem - |divisor|.
  - If trial is non-negative: rem=trial and quo LSB=1. Otherwise quo LSB=0.
  - count increments each edge; at count==WIDTH-1 the next state is FIX.
- FIX, edge E33:
  - z_low = qneg ? -quo : quo.
  - z_high = rneg ? -rem : rem.
  - ready=1 for exactly the following cycle, busy=0, go to IDLE.
- Latency: ready is high in the cycle after edge E33, i.e. 33 edges after the sampling edge. The divide-by-zero path takes 1 edge.
- Semantics:
  - Truncating division: quotient rounds toward zero.
  - The remainder takes the sign of the dividend.
  - The identity dividend == z_low*divisor + z_high holds (mod 2^32) for every divisor != 0.
- Overflow, 0x80000000 / 0xFFFFFFFF: the magnitude path yields quo=0x80000000; negation is not applied because qneg=0.
  - Result: z_low=0x80000000, z_high=0.
  - No flag; result wraps by definition.
- Dividend 0x80000000 with any divisor: |dividend| is 0x80000000 as unsigned. This is correct because the magnitudes are held unsigned.
- start while busy=1 (RUN/FIX): ignored, with no effect on the operation in flight. start asserted in the same cycle ready is high is accepted (state is IDLE).
- Operands are sampled only at E0. Changes to dividend/divisor during RUN have no effect.
- z_low, z_high and div_by_zero hold their values until the next completion or reset.
- ready is never high for more than one consecutive cycle per operation.

Test Plan:
- 100 / 7 (start one cycle) -> busy high 33 cycles; ready 33 edges after sampling; z_low=14, z_high=2, div_by_zero=0.
- -100 / 7 -> z_low=0xFFFFFFF2 (-14), z_high=0xFFFFFFFE (-2). Also 100 / -7 -> z_low=0xFFFFFFF2, z_high=2.
- 7 / 0 -> ready on the cycle after sampling, busy never high, z_low=0xFFFFFFFF, z_high=7, div_by_zero=1. A subsequent 9/3 clears the flag and gives z_low=3, z_high=0.
- 0x80000000 / 0xFFFFFFFF -> z_low=0x80000000, z_high=0. Also 0x80000000 / 2 -> z_low=0xC0000000, z_high=0.
- Start 50/5; pulse start again with 1/1 at edge E10 -> second request ignored; single ready at E33 with z_low=10, z_high=0.
- Start 1000/3; assert rst at E10 for one cycle -> all outputs 0, no ready pulse. A new start 1000/3 then completes normally with z_low=333, z_high=1.
- Randomized (optional): 10k signed pairs, divisor != 0 -> identity check and match against a reference model.
